fpu_op_sequencer: RTL and testbench
===================================

# fpu_op_sequencer

Operand-issue and result-collection stage wrapped around the single-cycle-registered floating-point adder (1-bit sign, 11-bit exponent, 20-bit mantissa). It accepts operand pairs over a valid/ready handshake, presents them to the adder and waits out the adder latency. It then captures the adder's result and status into a small output FIFO, which a downstream consumer drains with its own valid/ready handshake. Only one operation is in flight at a time.

## Interface
Parameters:
- FIFO_DEPTH, 4: result FIFO entries. Power of two, ≥2.

Ports:
- m_clk  in  1  clock; all state updates on rising edge.
- m_reset  in  1  asynchronous, active-low reset. Also drives the adder's m_reset.
- m_inValid  in  1  upstream operand pair valid.
- m_inReady  out  1  sequencer can accept an operand pair.
- m_inA  in  32  operand A.
- m_inB  in  32  operand B.
- m_fpuOpA  out  32  registered operand A to the adder.
- m_fpuOpB  out  32  registered operand B to the adder.
- m_fpuData  in  32  adder result.
- m_fpuStatus  in  g_eStatus  adder status.
- m_outValid  out  1  FIFO head valid.
- m_outReady  in  1  consumer takes the head.
- m_outData  out  32  FIFO head result.
- m_outStatus  out  g_eStatus  FIFO head status.
- m_busy  out  1  operation in flight (state ≠ IDLE).

## Operation
FSM states are IDLE, ISSUE and WAIT.
- **IDLE:** m_inReady = 1 when FIFO count < FIFO_DEPTH, otherwise 0.
  - An edge with m_inValid & m_inReady loads m_fpuOpA/m_fpuOpB from m_inA/m_inB and moves to ISSUE.
- **ISSUE:** m_inReady = 0. The adder samples its operands on this edge. Go to WAIT.
- **WAIT:** m_inReady = 0. On this edge, push {m_fpuData, m_fpuStatus} into the FIFO and go to IDLE.

FIFO behaviour:
- m_outValid = (count ≠ 0). m_outData and m_outStatus show the head entry.
- A pop occurs on an edge with m_outValid & m_outReady.
- A push always has room, because accept requires count < DEPTH and only one operation is in flight.
- Push and pop on the same edge leave count unchanged, and the entry order is preserved.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. count is log2(FIFO_DEPTH)+1 bits.
- m_outData and m_outStatus are don't-care while m_outValid = 0.

m_fpuOpA and m_fpuOpB hold their last values outside ISSUE and WAIT.

Reset (asynchronous, any state):
- state = IDLE.
- FIFO pointers and count = 0.
- m_fpuOpA = m_fpuOpB = 0.
- m_inReady = 1, m_outValid = 0, m_busy = 0.
- Counters (if compiled in) = 0.
- An in-flight operation is discarded and never appears at the output.

## Timing
- Accept edge N. Result is pushed on edge N+2. m_outValid rises after edge N+2, giving 3 cycles from accept to output.
- Maximum throughput is one operation per 3 cycles.
- m_inReady is combinational from state and count. It is low during ISSUE and WAIT.
- A pop on edge N+2 of a full FIFO frees space, so m_inReady is high in the cycle after that edge.

## Configuration
- FPU_SEQ_STATUS_CNT_EN defined:
  - Adds outputs m_cntInexact, m_cntUnderflow and m_cntOverflow, each 16 bits.
  - Each counter increments on every FIFO push whose status matches.
  - Counters saturate at 16'hFFFF and are cleared only by reset.
- FPU_SEQ_STATUS_CNT_EN undefined: the counter ports and logic are absent. Everything else is identical.

## Structure
- Package FPU_types:
  - existing g_eStatus;
  - new enum g_eSeqState {IDLE, ISSUE, WAIT};
  - new packed struct g_sResult {logic [31:0] data; g_eStatus status;}.
- Sub-module fpu_result_fifo (parameter FIFO_DEPTH; push/pop/full/empty/count), instantiated once.
- The FSM, operand registers and optional counters live in fpu_op_sequencer.

## Test plan
- **Reset:** assert m_reset=0 mid-run. Require m_outValid=0, m_inReady=1, m_busy=0 and m_fpuOpA=0 immediately, without waiting for a clock edge.
- **Single op:** A=32'h40000001, B=32'h40000001 accepted on edge N. Require m_outValid high after edge N+2 with m_outData=32'h40000002 and m_outStatus=EXACT.
- **Ordering:** three ops, each accepted in the first IDLE cycle the sequencer offers, with m_outReady=1:
  - (40000001, 40000001) → 40000002/EXACT;
  - (40100000, 40000001) → 40100000/INEXACT;
  - (00000001, 00000001) → 00000002/UNDERFLOW.
  - Require this output order and accept edges spaced 3 cycles apart.
- **Backpressure:** m_outReady=0 with FIFO_DEPTH=4 and four ops issued.
  - After the 4th push, require m_inReady=0.
  - Pulse m_outReady for one edge. Require the first result to pop and m_inReady=1 on the next cycle.
- **Reset mid-op:** accept an op, then assert reset while in ISSUE and release it. Require no output entry, then normal operation on the next op.
- **Counters (macro on):** run the ordering sequence. Require m_cntInexact=1, m_cntUnderflow=1 and m_cntOverflow=0.

Source files
------------

// File: rtl/fpu_op_sequencer_pkg.sv
// Shared types for the FPU operand sequencer and its result FIFO.
// Holds the adder status enum, the sequencer states and the FIFO entry layout.
package FPU_types;

  typedef enum logic [1:0] {
    EXACT,
    INEXACT,
    UNDERFLOW,
    OVERFLOW
  } g_eStatus;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } g_eSeqState;

  typedef struct packed {
    logic [31:0] data;
    g_eStatus    status;
  } g_sResult;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Small circular result FIFO between the adder and the downstream consumer.
// Pointers wrap modulo FIFO_DEPTH; count carries one extra bit for "full".
module fpu_result_fifo
  import FPU_types::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  g_sResult                      push_data_i,
  input  logic                          pop_i,
  output g_sResult                      pop_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  g_sResult      mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Operand issue / result collection around the registered FP adder.
// Define FPU_SEQ_STATUS_CNT_EN to add saturating per-status result counters.
module fpu_op_sequencer
  import FPU_types::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        m_clk,
  input  logic        m_reset,
  input  logic        m_inValid,
  output logic        m_inReady,
  input  logic [31:0] m_inA,
  input  logic [31:0] m_inB,
  output logic [31:0] m_fpuOpA,
  output logic [31:0] m_fpuOpB,
  input  logic [31:0] m_fpuData,
  input  g_eStatus    m_fpuStatus,
  output logic        m_outValid,
  input  logic        m_outReady,
  output logic [31:0] m_outData,
  output g_eStatus    m_outStatus,
`ifdef FPU_SEQ_STATUS_CNT_EN
  output logic [15:0] m_cntInexact,
  output logic [15:0] m_cntUnderflow,
  output logic [15:0] m_cntOverflow,
`endif
  output logic        m_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  g_eSeqState  state_q, state_d;
  logic [31:0] op_a_q, op_b_q;
  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full_unused;
  logic [AW:0] fifo_count;
  g_sResult    push_data;
  g_sResult    head;

  always_comb begin
    state_d   = state_q;
    m_inReady = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        m_inReady = (fifo_count < DEPTH_C);
        if (m_inValid && m_inReady) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        fifo_push = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) & m_inValid & m_inReady;

  always_ff @(posedge m_clk or negedge m_reset) begin
    if (!m_reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q <= m_inA;
        op_b_q <= m_inB;
      end
    end
  end

  assign m_fpuOpA = op_a_q;
  assign m_fpuOpB = op_b_q;
  assign m_busy   = (state_q != IDLE);

  assign push_data = '{data: m_fpuData, status: m_fpuStatus};
  assign fifo_pop  = m_outValid & m_outReady;

  fpu_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (m_clk),
    .rst_ni      (m_reset),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign m_outValid  = ~fifo_empty;
  assign m_outData   = head.data;
  assign m_outStatus = head.status;

`ifdef FPU_SEQ_STATUS_CNT_EN
  logic [15:0] cnt_inx_q, cnt_unf_q, cnt_ovf_q;

  always_ff @(posedge m_clk or negedge m_reset) begin
    if (!m_reset) begin
      cnt_inx_q <= '0;
      cnt_unf_q <= '0;
      cnt_ovf_q <= '0;
    end else if (fifo_push) begin
      if (m_fpuStatus == INEXACT)   cnt_inx_q <= sat_inc16(cnt_inx_q);
      if (m_fpuStatus == UNDERFLOW) cnt_unf_q <= sat_inc16(cnt_unf_q);
      if (m_fpuStatus == OVERFLOW)  cnt_ovf_q <= sat_inc16(cnt_ovf_q);
    end
  end

  assign m_cntInexact   = cnt_inx_q;
  assign m_cntUnderflow = cnt_unf_q;
  assign m_cntOverflow  = cnt_ovf_q;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a toy registered adder.
// Table vectors, hand sequences and random traffic against a queue model.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  import FPU_types::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    g_eStatus    s;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    g_eStatus    s;
  } vec_t;

  logic        m_clk = 1'b0;
  logic        m_reset = 1'b0;
  logic        m_inValid = 1'b0;
  logic        m_inReady;
  logic [31:0] m_inA = '0;
  logic [31:0] m_inB = '0;
  logic [31:0] m_fpuOpA, m_fpuOpB;
  logic [31:0] m_fpuData;
  g_eStatus    m_fpuStatus;
  logic        m_outValid;
  logic        m_outReady = 1'b0;
  logic [31:0] m_outData;
  g_eStatus    m_outStatus;
  logic        m_busy;
`ifdef FPU_SEQ_STATUS_CNT_EN
  logic [15:0] m_cntInexact, m_cntUnderflow, m_cntOverflow;
`endif

  always #5 m_clk = ~m_clk;

  fpu_op_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .m_clk         (m_clk),
    .m_reset       (m_reset),
    .m_inValid     (m_inValid),
    .m_inReady     (m_inReady),
    .m_inA         (m_inA),
    .m_inB         (m_inB),
    .m_fpuOpA      (m_fpuOpA),
    .m_fpuOpB      (m_fpuOpB),
    .m_fpuData     (m_fpuData),
    .m_fpuStatus   (m_fpuStatus),
    .m_outValid    (m_outValid),
    .m_outReady    (m_outReady),
    .m_outData     (m_outData),
    .m_outStatus   (m_outStatus),
`ifdef FPU_SEQ_STATUS_CNT_EN
    .m_cntInexact  (m_cntInexact),
    .m_cntUnderflow(m_cntUnderflow),
    .m_cntOverflow (m_cntOverflow),
`endif
    .m_busy        (m_busy)
  );

  // Toy adder: equal exponents add mantissas, else the larger operand wins.
  function automatic res_t fpu_stub(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    if (a[30:20] == b[30:20]) begin
      r.d = {a[31:20], a[19:0] + b[19:0]};
      r.s = EXACT;
    end else begin
      r.d = (a[30:20] > b[30:20]) ? a : b;
      r.s = INEXACT;
    end
    if (r.d[30:20] == 11'h000) r.s = UNDERFLOW;
    else if (r.d[30:20] == 11'h7FF) r.s = OVERFLOW;
    return r;
  endfunction

  res_t fpu_res;
  always_ff @(posedge m_clk or negedge m_reset) begin
    if (!m_reset) fpu_res <= '{d: 32'h0, s: EXACT};
    else          fpu_res <= fpu_stub(m_fpuOpA, m_fpuOpB);
  end
  assign m_fpuData   = fpu_res.d;
  assign m_fpuStatus = fpu_res.s;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ph = 0;
  res_t pend;
  logic [31:0] cur_a, cur_b;
  res_t mq[$];
  res_t got_q[$];
  int   n_inx = 0, n_unf = 0, n_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    ph = 0;
    mq.delete();
    got_q.delete();
    n_inx = 0;
    n_unf = 0;
    n_ovf = 0;
  endtask

  // Called mid-cycle; checks outputs, then advances one clock edge.
  task automatic tick(output bit acc);
    bit   pop;
    logic rdy;
    rdy = (ph == 0) && (mq.size() < DEPTH);
    chk("inReady", 32'(m_inReady), 32'(rdy));
    chk("outValid", 32'(m_outValid), 32'(mq.size() != 0));
    chk("busy", 32'(m_busy), 32'(ph != 0));
    if (mq.size() != 0) begin
      chk("outData", m_outData, mq[0].d);
      chk("outStatus", 32'(m_outStatus), 32'(mq[0].s));
    end
    if (ph != 0) begin
      chk("fpuOpA", m_fpuOpA, cur_a);
      chk("fpuOpB", m_fpuOpB, cur_b);
    end
`ifdef FPU_SEQ_STATUS_CNT_EN
    chk("cntInexact", 32'(m_cntInexact), 32'(n_inx));
    chk("cntUnderflow", 32'(m_cntUnderflow), 32'(n_unf));
    chk("cntOverflow", 32'(m_cntOverflow), 32'(n_ovf));
`endif
    acc = m_inValid && rdy;
    pop = m_outReady && (mq.size() != 0);
    if (pop) got_q.push_back('{d: m_outData, s: m_outStatus});
    @(posedge m_clk);
    if (pop) mq.delete(0);
    if (ph == 1) begin
      mq.push_back(pend);
      if (pend.s == INEXACT   && n_inx < 65535) n_inx++;
      if (pend.s == UNDERFLOW && n_unf < 65535) n_unf++;
      if (pend.s == OVERFLOW  && n_ovf < 65535) n_ovf++;
    end
    if (acc) begin
      ph = 2;
      cur_a = m_inA;
      cur_b = m_inB;
      pend = fpu_stub(m_inA, m_inB);
    end else if (ph != 0) begin
      ph--;
    end
    cyc++;
    @(negedge m_clk);
  endtask

  task automatic accept_op(output int at);
    bit acc = 1'b0;
    int g = 0;
    while (!acc && g < 20) begin
      tick(acc);
      g++;
    end
    chk("accept_bound", 32'(acc), 32'd1);
    at = cyc;
  endtask

  vec_t tbl [5];
  int   acc_cyc [5];
  bit   acc;
  int   dummy;
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{a: 32'h40000001, b: 32'h40000001, d: 32'h40000002, s: EXACT};
    tbl[1] = '{a: 32'h40100000, b: 32'h40000001, d: 32'h40100000, s: INEXACT};
    tbl[2] = '{a: 32'h00000001, b: 32'h00000001, d: 32'h00000002, s: UNDERFLOW};
    tbl[3] = '{a: 32'h7FF00000, b: 32'h7FF00001, d: 32'h7FF00001, s: OVERFLOW};
    tbl[4] = '{a: 32'h3FF00003, b: 32'h3FF00004, d: 32'h3FF00007, s: EXACT};

    #1;
    chk("rst0_outValid", 32'(m_outValid), 32'd0);
    chk("rst0_inReady", 32'(m_inReady), 32'd1);
    chk("rst0_busy", 32'(m_busy), 32'd0);
    chk("rst0_fpuOpA", m_fpuOpA, 32'd0);
    repeat (2) @(posedge m_clk);
    @(negedge m_clk);
    m_reset = 1'b1;
    reset_model();

    // Ordering / single op / counters, via the vector table
    m_outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        m_inValid = 1'b0;
        repeat (3) tick(acc);
`ifdef FPU_SEQ_STATUS_CNT_EN
        chk("ord_cntInexact", 32'(m_cntInexact), 32'd1);
        chk("ord_cntUnderflow", 32'(m_cntUnderflow), 32'd1);
        chk("ord_cntOverflow", 32'(m_cntOverflow), 32'd0);
`endif
      end
      m_inA = tbl[i].a;
      m_inB = tbl[i].b;
      m_inValid = 1'b1;
      accept_op(acc_cyc[i]);
    end
    m_inValid = 1'b0;
    repeat (6) tick(acc);
    chk("ord_spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("ord_spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    chk("tbl_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        chk("tbl_data", got_q[i].d, tbl[i].d);
        chk("tbl_status", 32'(got_q[i].s), 32'(tbl[i].s));
      end
    end

    // Backpressure: fill the FIFO, then pop one entry
    m_outReady = 1'b0;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      m_inA = tbl[i].a;
      m_inB = tbl[i].b;
      m_inValid = 1'b1;
      accept_op(dummy);
    end
    m_inValid = 1'b0;
    repeat (3) tick(acc);
    chk("bp_full_inReady", 32'(m_inReady), 32'd0);
    chk("bp_full_outValid", 32'(m_outValid), 32'd1);
    m_outReady = 1'b1;
    tick(acc);
    m_outReady = 1'b0;
    chk("bp_pop_inReady", 32'(m_inReady), 32'd1);
    chk("bp_pop_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("bp_pop_data", got_q[0].d, tbl[0].d);
    chk("bp_new_head", m_outData, tbl[1].d);
    m_outReady = 1'b1;
    repeat (6) tick(acc);

    // Reset while the operation sits in ISSUE
    m_inA = tbl[2].a;
    m_inB = tbl[2].b;
    m_inValid = 1'b1;
    accept_op(dummy);
    m_inValid = 1'b0;
    m_reset = 1'b0;
    #1;
    chk("rst_outValid", 32'(m_outValid), 32'd0);
    chk("rst_inReady", 32'(m_inReady), 32'd1);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_fpuOpA", m_fpuOpA, 32'd0);
    reset_model();
    repeat (2) @(posedge m_clk);
    @(negedge m_clk);
    m_reset = 1'b1;
    repeat (4) tick(acc);
    chk("rst_no_output", 32'(got_q.size()), 32'd0);
    m_inA = tbl[1].a;
    m_inB = tbl[1].b;
    m_inValid = 1'b1;
    accept_op(dummy);
    m_inValid = 1'b0;
    repeat (4) tick(acc);
    chk("rst_next_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("rst_next_data", got_q[0].d, tbl[1].d);

    // Random traffic with a stretch of heavy backpressure
    for (int i = 0; i < 600; i++) begin
      m_inValid = ($urandom_range(0, 2) != 0);
      if (i >= 200 && i < 350) m_outReady = ($urandom_range(0, 7) == 0);
      else                     m_outReady = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb[30:20] = ra[30:20];
      m_inA = ra;
      m_inB = rb;
      tick(acc);
    end
    m_inValid = 1'b0;
    m_outReady = 1'b1;
    repeat (10) tick(acc);
    chk("final_drained", 32'(m_outValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
